// File: rtl/rv_pkg.sv
// Shared RV32 datapath types: register index/word types, register-file constants, ALU opcodes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam int       NUM_REGS = 32;

    // Operation select shared by decode and the ALU.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/reg_file_rport.sv
// One registered read port: x0 forces zero, a same-cycle write is bypassed, otherwise storage is read.
// Latency: 1 cycle from address to data.
// Backpressure: rd_en=0 holds the output register (stall); held data does not track later writes.
module reg_file_rport
    import rv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] next_data;

    // Select the value to capture: zero register first, then the write bus, then storage.
    always_comb begin
        next_data = regs[addr];
        if (addr == ADDR_W'(REG_ZERO)) begin
            next_data = '0;
        end else if (we && (wr_addr == addr)) begin
            next_data = wr_data;
        end
    end

    // Output register: cleared by reset, loads only when rd_en is high, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (rd_en) begin
            data <= next_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// RV32 integer register file: 2 registered read ports, 1 write port, x0 hardwired to zero.
// Latency: reads 1 cycle (same-cycle write bypassed); writes visible in storage after 1 cycle.
// Backpressure: rd_en=0 stalls both read outputs; writes are never stalled.
module reg_file
    import rv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Storage: reset clears every entry; writes to entry 0 are discarded so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd_addr != ADDR_W'(REG_ZERO))) begin
            regs[rd_addr] <= wr_data;
        end
    end

    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport1 (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .addr    (rs1_addr),
        .regs    (regs),
        .we      (we),
        .wr_addr (rd_addr),
        .wr_data (wr_data),
        .data    (rs1_data)
    );

    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport2 (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .addr    (rs2_addr),
        .regs    (regs),
        .we      (we),
        .wr_addr (rd_addr),
        .wr_data (wr_data),
        .data    (rs2_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: reference model plus hand-computed directed checks.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises rd_en stalls, reset during stall and reset-vs-write.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;

    int tests;
    int fails;

    reg_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_en    (rd_en),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (we),
        .rd_addr  (rd_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the architectural register state after this edge's write,
    // and the read outputs as a read of that post-write state (x0 is never stored).
    logic [31:0] m_regs [32];
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    bit          armed;

    initial armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_rs1 = 32'd0;
            m_rs2 = 32'd0;
            armed = 1'b1;
        end else begin
            if (we && rd_addr != 5'd0) m_regs[rd_addr] = wr_data;
            if (rd_en) begin
                m_rs1 = m_regs[rs1_addr];
                m_rs2 = m_regs[rs2_addr];
            end
        end
    end

    // Compare every cycle once the model has been reset.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            tests++;
            if (rs1_data !== m_rs1) begin
                fails++;
                $display("FAIL model_rs1 t=%0t got=%h exp=%h", $time, rs1_data, m_rs1);
            end
            tests++;
            if (rs2_data !== m_rs2) begin
                fails++;
                $display("FAIL model_rs2 t=%0t got=%h exp=%h", $time, rs2_data, m_rs2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs (from a falling edge), then sample just after the rising edge.
    task automatic step(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] a1, input logic [4:0] a2);
        reset    = rst;
        we       = w;
        rd_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rs1_addr = a1;
        rs2_addr = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_edge();
        @(negedge clk);
    endtask

    logic [32:0] alu;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; we = 1'b0; rd_addr = '0; wr_data = '0;
        rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);
        idle_edge();

        // Load x5 (bypass shows it at once), reset, then x5 and x0 read 0
        step(0, 1, 5, 32'hDEADBEEF, 1, 5, 0);
        check("x5_bypass", rs1_data, 32'hDEADBEEF);
        idle_edge();
        step(1, 0, 0, 0, 1, 5, 5);
        check("post_reset_rs1", rs1_data, 32'h0);
        check("post_reset_rs2", rs2_data, 32'h0);
        idle_edge();
        step(0, 0, 0, 0, 1, 5, 0);
        check("x5_cleared", rs1_data, 32'h0);
        check("x0_read", rs2_data, 32'h0);
        idle_edge();

        // Basic write/read and subtract
        step(0, 1, 1, 32'd10, 1, 0, 0); idle_edge();
        step(0, 1, 2, 32'd7, 1, 0, 0);  idle_edge();
        step(0, 0, 0, 0, 1, 1, 2);
        check("rd_x1", rs1_data, 32'd10);
        check("rd_x2", rs2_data, 32'd7);
        alu = {1'b0, rs1_data} + {1'b0, ~rs2_data} + 33'd1;
        check("sub_result", alu[31:0], 32'd3);
        check("sub_cout", {31'd0, alu[32]}, 32'd1);
        check("sub_over", {31'd0, (rs1_data[31] != rs2_data[31]) && (alu[31] != rs1_data[31])}, 32'd0);
        idle_edge();

        // x0 protection: write to x0 is dropped and never bypassed
        step(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        check("x0_no_bypass", rs1_data, 32'h0);
        idle_edge();
        step(0, 0, 0, 0, 1, 0, 0);
        check("x0_still_zero", rs1_data, 32'h0);
        idle_edge();

        // Bypass on both ports, then add 1 wraps to 0
        step(0, 1, 3, 32'd1, 1, 0, 0); idle_edge();
        step(0, 1, 3, 32'hFFFFFFFF, 1, 3, 3);
        check("bypass_rs1", rs1_data, 32'hFFFFFFFF);
        check("bypass_rs2", rs2_data, 32'hFFFFFFFF);
        alu = {1'b0, rs1_data} + 33'd1;
        check("add_result", alu[31:0], 32'h0);
        check("add_cout", {31'd0, alu[32]}, 32'd1);
        idle_edge();

        // Stall hold: outputs ignore writes until rd_en returns
        step(0, 1, 4, 32'h11, 1, 0, 0); idle_edge();
        step(0, 0, 0, 0, 1, 4, 4);
        check("stall_pre", rs1_data, 32'h11);
        idle_edge();
        step(0, 1, 4, 32'h22, 0, 4, 4);
        check("stall_c1", rs1_data, 32'h11);
        idle_edge();
        step(0, 0, 0, 0, 0, 4, 4);
        check("stall_c2", rs2_data, 32'h11);
        idle_edge();
        step(0, 0, 0, 0, 0, 4, 4);
        check("stall_c3", rs1_data, 32'h11);
        idle_edge();
        step(0, 0, 0, 0, 1, 4, 4);
        check("stall_release", rs1_data, 32'h22);
        idle_edge();

        // Reset beats write
        step(1, 1, 6, 32'h55, 1, 6, 6);
        check("rst_vs_wr_out", rs1_data, 32'h0);
        idle_edge();
        step(0, 0, 0, 0, 1, 6, 6);
        check("x6_dropped", rs1_data, 32'h0);
        idle_edge();

        // Reset released mid-stall: outputs stay 0 until rd_en
        step(0, 1, 7, 32'h77, 1, 0, 0); idle_edge();
        step(0, 0, 0, 0, 1, 7, 7);      idle_edge();
        step(1, 0, 0, 0, 0, 7, 7);      idle_edge();
        step(0, 1, 7, 32'h77, 0, 7, 7);
        check("stall_after_rst", rs1_data, 32'h0);
        idle_edge();
        step(0, 0, 0, 0, 1, 7, 7);
        check("rd_after_rst_stall", rs2_data, 32'h77);
        idle_edge();

        // Sweep: fill every register while reading neighbours, then read back pairs
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 5'(i), 32'h01010101 * i, 1, 5'(i - 1), 5'(i));
            idle_edge();
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 1, 5'(i), 5'(31 - i));
            idle_edge();
        end
        step(0, 0, 0, 0, 1, 31, 1);
        check("sweep_x31", rs1_data, 32'h1F1F1F1F);
        check("sweep_x1", rs2_data, 32'h01010101);
        idle_edge();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Two-read/one-write 32-entry integer register file for the RV32 datapath. It sits directly upstream of the ALU: its two registered read ports drive the ALU `A` operand and the pre-mux `B` operand. The writeback stage returns results through its single write port. Register x0 is hardwired to zero, reads are registered with a hold control for pipeline stalls, and a same-cycle write is bypassed to the reads.

## Interface
- `DATA_W`, default 32: register and port data width.
- `ADDR_W`, default 5: register index width; depth is 2**ADDR_W.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `rs1_addr` input, ADDR_W bits: read port 1 index.
- `rs2_addr` input, ADDR_W bits: read port 2 index.
- `rd_en` input, 1 bit: 1 = capture new read data this edge; 0 = hold both read outputs (stall).
- `rs1_data` output, DATA_W bits: registered read data, port 1 (ALU `A`).
- `rs2_data` output, DATA_W bits: registered read data, port 2 (ALU `B` path).
- `we` input, 1 bit: write enable from writeback.
- `rd_addr` input, ADDR_W bits: write index.
- `wr_data` input, DATA_W bits: write data.

## Operation
- Storage: 2**ADDR_W words of DATA_W bits. Entry 0 is never written and always reads 0.
- Write: at a rising edge with `reset`=0, `we`=1 and `rd_addr`!=0, `regs[rd_addr] <= wr_data`.
  - `we`=1 with `rd_addr`=0 is legal and a no-op.
- Read, per port, evaluated at a rising edge with `reset`=0 and `rd_en`=1, in priority order:
  1. If `rsN_addr`==0, the output gets 0.
  2. Otherwise, if `we`=1 and `rd_addr`==`rsN_addr`, the output gets `wr_data` (write-through bypass).
  3. Otherwise, the output gets `regs[rsN_addr]`.
- Both ports are independent. `rs1_addr`==`rs2_addr` is legal, and both ports return identical data.
- `rd_en`=0: `rs1_data` and `rs2_data` hold their values. Writes still occur.
  - A write that lands while the outputs are held is not reflected in them until the next `rd_en`=1 edge. The outputs do not snoop writes; that forwarding belongs to the hazard unit.
- Reset: every storage entry is cleared to 0, and `rs1_data` and `rs2_data` are cleared to 0.
  - Reset overrides `we` and `rd_en` in the same cycle.
  - A write presented in the reset cycle is dropped.
- No X propagation: every index in range is valid. With ADDR_W=5 no out-of-range index exists.

## Timing
- Read latency: 1 cycle. Address presented before edge N gives data valid after edge N.
- Write latency: 1 cycle. A write at edge N is readable from storage by a read captured at edge N+1. A read captured at edge N itself gets the value through the bypass.
- Outputs are glitch-free register outputs with no combinational input-to-output path. The ALU's combinational flags therefore see stable operands for a full cycle.
- Reset value of all outputs: `rs1_data`=0, `rs2_data`=0.
- Reset deasserted mid-stall: the outputs stay 0 until the first `rd_en`=1 edge.

## Structure
- Shared package `rv_pkg`:
  - typedef `reg_idx_t` (logic [4:0]);
  - typedef `word_t` (logic [31:0]);
  - constant `REG_ZERO` = 5'd0;
  - constant `NUM_REGS` = 32.
  - The ALU opcode enum lives in the same package so decode can share it.
- One sub-module, `reg_file_rport`, instantiated twice. It takes an index, the storage array value, and the write-bus snoop, and implements the zero / bypass / storage priority, the output register, and `rd_en` hold.
- The storage array and write logic stay in `reg_file`.

## Test plan
- Reset: load x5=0xDEADBEEF, assert `reset` one cycle, then read x5 and x0 → both 0. Outputs are 0 in the cycle after reset.
- Basic write/read: write x1=10 and x2=7, then read rs1=x1, rs2=x2 one cycle later → `rs1_data`=10, `rs2_data`=7. Feed both to the ALU with subtract → result 3, `c_out`=1, `over`=0.
- x0 protection: write x0=0xFFFFFFFF while reading rs1=x0 in the same cycle, then read x0 again → 0 both times (no bypass to x0).
- Bypass: with x3 holding 1, write x3=0xFFFFFFFF and read rs1=x3, rs2=x3 in the same cycle → both outputs 0xFFFFFFFF. Feed to the ALU with B=1 add → result 0, `zero`=1, `c_out`=1.
- Stall hold: read x4=0x11, then drop `rd_en` for 3 cycles while writing x4=0x22 → output stays 0x11. Raise `rd_en` → 0x22 appears the next cycle.
- Reset beats write: assert `reset` with `we`=1, x6=0x55 in the same cycle, then read x6 → 0.
